// File: rtl/saradc_readout_if.sv
// SAR ADC readout bus: converter GO/VALID/SAMPLE/RESULT plus output stream.
// master = readout block side, slave = converter/consumer side.
interface saradc_readout_if #(
  parameter int NBITS = 8
);
  logic             GO;
  logic             VALID;
  logic             SAMPLE;
  logic [NBITS-1:0] RESULT;
  logic [NBITS-1:0] OUT_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;

  modport master (
    output GO,
    input  VALID,
    input  SAMPLE,
    input  RESULT,
    output OUT_DATA,
    output OUT_VALID,
    input  OUT_READY
  );

  modport slave (
    input  GO,
    output VALID,
    output SAMPLE,
    output RESULT,
    input  OUT_DATA,
    input  OUT_VALID,
    output OUT_READY
  );
endinterface

// File: rtl/saradc_readout.sv
// SAR ADC conversion sequencer, 1/2/4/8 averager and output FIFO.
// Ports: CLK/RST, START/CONT/AVG control, BUSY/OVF/TMO/CLR_ERR status, bus (master).
module saradc_readout #(
  parameter int NBITS      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TMO_CYCLES = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       CONT,
  input  logic [1:0] AVG,
  input  logic       CLR_ERR,
  output logic       BUSY,
  output logic       OVF,
  output logic       TMO,
  saradc_readout_if.master bus
);
  localparam int AW = NBITS + 3;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TMO_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_ACC, S_PUSH
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_valid_q;
  logic [1:0]       r_avg_l;
  logic [AW-1:0]    r_acc;
  logic [2:0]       r_cnt;
  logic [TW-1:0]    r_tmo_cnt;
  logic [NBITS-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [PW:0]      r_fcnt;

  logic             w_rise;
  logic             w_tmo_hit;
  logic             w_last;
  logic             w_start;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_wr_en;
  logic             w_drop;
  logic [NBITS-1:0] w_sample;

  assign w_rise = bus.VALID & ~r_valid_q;

  // WAIT starts the cycle after GO, so the final WAIT cycle carries
  // count TMO_CYCLES-2 and TMO shows TMO_CYCLES cycles after GO.
  assign w_tmo_hit = (r_state == S_WAIT) & ~w_rise &
                     (r_tmo_cnt == TW'(TMO_CYCLES - 2));

  assign w_last  = ({1'b0, r_cnt} == ((4'd1 << r_avg_l) - 4'd1));
  assign w_start = ((r_state == S_IDLE) & (START | CONT)) |
                   ((r_state == S_PUSH) & CONT);

  assign w_sample = NBITS'(r_acc >> r_avg_l);

  assign w_full  = (r_fcnt == (PW+1)'(FIFO_DEPTH));
  assign w_pop   = bus.OUT_VALID & bus.OUT_READY;
  assign w_wr_en = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (START | CONT) w_next = S_REQ;
      S_REQ:  w_next = S_WAIT;
      S_WAIT: begin
        if (w_rise)         w_next = S_ACC;
        else if (w_tmo_hit) w_next = S_IDLE;
      end
      S_ACC:  w_next = w_last ? S_PUSH : S_REQ;
      S_PUSH: w_next = CONT ? S_REQ : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.GO = 1'b0;
    w_push = 1'b0;
    BUSY   = bus.SAMPLE;
    unique case (r_state)
      S_IDLE: BUSY   = bus.SAMPLE;
      S_REQ:  begin bus.GO = 1'b1; BUSY = 1'b1; end
      S_PUSH: begin w_push = 1'b1; BUSY = 1'b1; end
      default: BUSY  = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_valid_q <= 1'b0;
      r_avg_l   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_tmo_cnt <= '0;
      OVF       <= 1'b0;
      TMO       <= 1'b0;
    end else begin
      r_valid_q <= bus.VALID;
      if (w_start) begin
        r_avg_l <= AVG;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else begin
        if (r_state == S_WAIT && w_rise)
          r_acc <= r_acc + AW'(bus.RESULT);
        if (r_state == S_ACC && !w_last)
          r_cnt <= r_cnt + 3'd1;
      end
      if (r_state == S_REQ)       r_tmo_cnt <= '0;
      else if (r_state == S_WAIT) r_tmo_cnt <= r_tmo_cnt + TW'(1);
      if (w_drop)       OVF <= 1'b1;
      else if (CLR_ERR) OVF <= 1'b0;
      if (w_tmo_hit)    TMO <= 1'b1;
      else if (CLR_ERR) TMO <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr] <= w_sample;
        r_wr        <= r_wr + PW'(1);
      end
      if (w_pop) r_rd <= r_rd + PW'(1);
      if (w_wr_en && !w_pop)      r_fcnt <= r_fcnt + (PW+1)'(1);
      else if (!w_wr_en && w_pop) r_fcnt <= r_fcnt - (PW+1)'(1);
    end
  end

  assign bus.OUT_VALID = (r_fcnt != '0);
  assign bus.OUT_DATA  = r_mem[r_rd];
endmodule

// File: tb/tb_saradc_readout.sv
// Directed bench for saradc_readout with a small converter model.
// Model answers each GO with VALID/RESULT after lat cycles.
module tb_saradc_readout;
  localparam int TMO = 40;

  logic       CLK;
  logic       RST;
  logic       START;
  logic       CONT;
  logic [1:0] AVG;
  logic       CLR_ERR;
  logic       BUSY;
  logic       OVF;
  logic       TMO_o;

  saradc_readout_if #(.NBITS(8)) bus ();

  saradc_readout #(
    .NBITS(8), .FIFO_DEPTH(4), .TMO_CYCLES(TMO)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .CONT(CONT),
    .AVG(AVG), .CLR_ERR(CLR_ERR), .BUSY(BUSY),
    .OVF(OVF), .TMO(TMO_o), .bus(bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_go    = 0;
  int pend    = 0;
  int lat     = 5;
  bit mute    = 0;
  logic [7:0] res_q[$];
  logic [7:0] nxt_res;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    bus.VALID = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        bus.VALID  = 1'b1;
        bus.RESULT = nxt_res;
      end
    end
    if (bus.GO === 1'b1) begin
      n_go++;
      if (!mute) begin
        pend    = lat;
        nxt_res = (res_q.size() > 0) ? res_q.pop_front() : 8'h00;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic pop1();
    bus.OUT_READY = 1'b1;
    tick();
    bus.OUT_READY = 1'b0;
  endtask

  task automatic clr_err();
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
  endtask

  task automatic wait_ov(input int bound, output int cyc);
    cyc = 0;
    while (bus.OUT_VALID !== 1'b1 && cyc < bound) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_idle(input int bound);
    int c = 0;
    while (BUSY !== 1'b0 && c < bound) begin
      tick();
      c++;
    end
  endtask

  task automatic wait_go(input int n, input int bound);
    int c = 0;
    while (n_go < n && c < bound) begin
      tick();
      c++;
    end
  endtask

  initial begin
    int cyc;
    RST = 1'b0; START = 1'b0; CONT = 1'b0; AVG = 2'd0;
    CLR_ERR = 1'b0; bus.SAMPLE = 1'b0; bus.OUT_READY = 1'b0;
    bus.VALID = 1'b0; bus.RESULT = 8'h00;
    tick(3);
    chk("rst_go", bus.GO, 0);
    chk("rst_ov", bus.OUT_VALID, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_tmo", TMO_o, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_data", bus.OUT_DATA, 0);
    RST = 1'b1;
    tick(2);

    // single shot, AVG=0
    res_q.push_back(8'hA5);
    n_go = 0;
    pulse_start();
    chk("t1_go", bus.GO, 1);
    wait_ov(50, cyc);
    chk("t1_lat", cyc, 8);
    chk("t1_data", bus.OUT_DATA, 8'hA5);
    chk("t1_busy", BUSY, 0);
    tick(10);
    chk("t1_ngo", n_go, 1);
    pop1();
    chk("t1_pop", bus.OUT_VALID, 0);
    bus.SAMPLE = 1'b1;
    tick();
    chk("t1_sample_busy", BUSY, 1);
    bus.SAMPLE = 1'b0;
    tick();

    // AVG=2 burst, AVG change mid-burst ignored
    res_q = '{8'd10, 8'd11, 8'd12, 8'd14};
    n_go = 0;
    AVG = 2'd2;
    pulse_start();
    tick(3);
    AVG = 2'd0;
    wait_ov(200, cyc);
    chk("t2_ngo", n_go, 4);
    chk("t2_data", bus.OUT_DATA, 11);
    pop1();
    chk("t2_pop", bus.OUT_VALID, 0);

    // continuous with stalled consumer -> overflow
    res_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    n_go = 0;
    CONT = 1'b1;
    wait_go(5, 200);
    chk("t3_go5", n_go, 5);
    chk("t3_ovf0", OVF, 0);
    wait_go(6, 50);
    chk("t3_ovf1", OVF, 1);
    CONT = 1'b0;
    wait_idle(50);
    chk("t3_ngo", n_go, 6);
    bus.OUT_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_rv", bus.OUT_VALID, 1);
      chk("t3_rd", bus.OUT_DATA, k + 1);
      tick();
    end
    bus.OUT_READY = 1'b0;
    chk("t3_empty", bus.OUT_VALID, 0);
    clr_err();
    chk("t3_clr", OVF, 0);

    // timeout
    mute = 1;
    n_go = 0;
    pulse_start();
    chk("t4_go", bus.GO, 1);
    cyc = 0;
    while (TMO_o !== 1'b1 && cyc < 300) begin
      tick();
      cyc++;
    end
    chk("t4_lat", cyc, TMO);
    chk("t4_idle", BUSY, 0);
    chk("t4_nopush", bus.OUT_VALID, 0);
    clr_err();
    chk("t4_clr", TMO_o, 0);
    mute = 0;
    res_q = '{8'h3C};
    pulse_start();
    wait_ov(50, cyc);
    chk("t4_next", bus.OUT_DATA, 8'h3C);
    pop1();

    // CONT dropped inside second conversion of AVG=1 burst
    res_q = '{8'd20, 8'd30, 8'd99};
    n_go = 0;
    AVG = 2'd1;
    CONT = 1'b1;
    wait_go(2, 100);
    tick();
    CONT = 1'b0;
    wait_idle(50);
    chk("t5_ov", bus.OUT_VALID, 1);
    chk("t5_data", bus.OUT_DATA, 25);
    tick(20);
    chk("t5_ngo", n_go, 2);
    pop1();
    chk("t5_pop", bus.OUT_VALID, 0);

    // reset while waiting with two entries queued
    AVG = 2'd0;
    res_q = '{8'd7, 8'd8, 8'd9};
    pulse_start();
    wait_idle(50);
    pulse_start();
    wait_idle(50);
    n_go = 0;
    pulse_start();
    tick();
    chk("t6_busy_pre", BUSY, 1);
    chk("t6_head_pre", bus.OUT_DATA, 7);
    RST = 1'b0;
    #1;
    chk("t6_go", bus.GO, 0);
    chk("t6_ov", bus.OUT_VALID, 0);
    chk("t6_ovf", OVF, 0);
    chk("t6_tmo", TMO_o, 0);
    chk("t6_busy", BUSY, 0);
    tick(2);
    RST = 1'b1;
    tick(10);
    chk("t6_late_ov", bus.OUT_VALID, 0);
    chk("t6_late_busy", BUSY, 0);
    chk("t6_ngo", n_go, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
